// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one block memory port between I-cache and D-cache
module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_MEM_READ,
    input  logic [ADDR_W-1:0]  I_MEM_ADDRESS,
    output logic [BLOCK_W-1:0] I_MEM_READDATA,
    output logic               I_MEM_BUSYWAIT,
    input  logic               D_MEM_READ,
    input  logic               D_MEM_WRITE,
    input  logic [ADDR_W-1:0]  D_MEM_ADDRESS,
    input  logic [BLOCK_W-1:0] D_MEM_WRITEDATA,
    output logic [BLOCK_W-1:0] D_MEM_READDATA,
    output logic               D_MEM_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT,
    output logic               GRANT_D,
    output logic               ARB_ERROR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic       last_d;
    logic [7:0] wdog;
    logic [7:0] wdog_inc;
    logic       error_flag;
    logic       req_i;
    logic       req_d;
    logic       pick_d;
    logic       serving;
    logic       done;

    assign req_i    = I_MEM_READ;
    assign req_d    = D_MEM_READ | D_MEM_WRITE;
    // On a tie the requester that did not own the last transaction wins.
    assign pick_d   = req_d && (!req_i || !last_d);
    assign serving  = (state == SERVE_I) || (state == SERVE_D);
    // The watchdog is zero only on the first serve cycle, so it doubles as the
    // "at least one cycle spent in SERVE" qualifier for completion.
    assign done     = serving && (wdog != 8'd0) && !MEM_BUSYWAIT;
    assign wdog_inc = wdog + 8'd1;

    assign GRANT_D   = last_d;
    assign ARB_ERROR = error_flag;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: grant, hold until completion, one release cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_next = pick_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (done) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Busywaits drop only during the owner's release cycle.
    always_comb begin
        I_MEM_BUSYWAIT = I_MEM_READ && !((state == RELEASE) && !last_d);
        D_MEM_BUSYWAIT = req_d && !((state == RELEASE) && last_d);
    end

    // Memory-side registers, read-data capture, ownership and watchdog.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            MEM_READ       <= 1'b0;
            MEM_WRITE      <= 1'b0;
            MEM_ADDRESS    <= '0;
            MEM_WRITEDATA  <= '0;
            I_MEM_READDATA <= '0;
            D_MEM_READDATA <= '0;
            last_d         <= 1'b0;
            wdog           <= 8'd0;
            error_flag     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i || req_d) begin
                        last_d <= pick_d;
                        if (pick_d) begin
                            // A simultaneous read+write from the D side is treated as a write.
                            MEM_ADDRESS <= D_MEM_ADDRESS;
                            MEM_WRITE   <= D_MEM_WRITE;
                            MEM_READ    <= !D_MEM_WRITE;
                            if (D_MEM_WRITE) begin
                                MEM_WRITEDATA <= D_MEM_WRITEDATA;
                            end
                        end else begin
                            MEM_ADDRESS <= I_MEM_ADDRESS;
                            MEM_READ    <= 1'b1;
                            MEM_WRITE   <= 1'b0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (done) begin
                        if (MEM_READ) begin
                            if (state == SERVE_D) begin
                                D_MEM_READDATA <= MEM_READDATA;
                            end else begin
                                I_MEM_READDATA <= MEM_READDATA;
                            end
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        wdog      <= 8'd0;
                    end else if (wdog != 8'hFF) begin
                        // Saturating count; a stuck transaction keeps waiting.
                        wdog <= wdog_inc;
                        if (wdog_inc == TIMEOUT_8) begin
                            error_flag <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
